// File: rtl/quad_bcd_updn_counter.sv
// Quadrature decoder driving a DIGITS-wide cascaded BCD up/down counter.
// Phases are synchronized, primed after reset, x4-decoded and counted modulo 10^DIGITS.
module quad_bcd_updn_counter #(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  qa,
  input  logic                  qb,
  input  logic                  load,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  dir,
  output logic                  maxmin,
  output logic                  wrap,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_INIT = PW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_ILL
  } step_e;

  logic [SYNC_STAGES-1:0] sa_q, sb_q;
  logic [1:0]             prev_q, prev_d;
  logic [PW-1:0]          prime_q, prime_d;
  logic [W-1:0]           q_q, q_d;
  logic                   dir_q, dir_d;
  logic                   wrap_q, wrap_d;
  logic                   err_q, err_d;

  logic [1:0]   s;
  step_e        step;
  logic [W-1:0] inc_val, dec_val, load_val;
  logic         load_bad, all9, all0;
  logic         carry, borrow;
  logic [3:0]   digit;

  assign s = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};

  // Up order is 00 -> 10 -> 11 -> 01 -> 00; a two-bit change is illegal.
  always_comb begin
    step = STEP_NONE;
    case ({prev_q, s})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_UP;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step = STEP_DN;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step = STEP_ILL;
      default:                                step = STEP_NONE;
    endcase
  end

  // Ripple carry/borrow through the digits; a surviving carry means all nines.
  always_comb begin
    inc_val  = '0;
    dec_val  = '0;
    load_val = '0;
    load_bad = 1'b0;
    carry    = 1'b1;
    borrow   = 1'b1;
    digit    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = q_q[4*i +: 4];
      if (!carry) begin
        inc_val[4*i +: 4] = digit;
      end else if (digit == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else begin
        inc_val[4*i +: 4] = digit + 4'd1;
        carry = 1'b0;
      end
      if (!borrow) begin
        dec_val[4*i +: 4] = digit;
      end else if (digit == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else begin
        dec_val[4*i +: 4] = digit - 4'd1;
        borrow = 1'b0;
      end
      if (d[4*i +: 4] > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_val[4*i +: 4] = d[4*i +: 4];
      end
    end
    all9 = carry;
    all0 = borrow;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    prev_d  = s;
    prime_d = prime_q;
    q_d     = q_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    err_d   = err_q;

    if (prime_q != '0) begin
      prime_d = prime_q - PW'(1);
    end

    if (!load) begin
      q_d   = load_val;
      err_d = load_bad;
    end else if (prime_q == '0) begin
      if (step == STEP_ILL) begin
        err_d = 1'b1;
      end
      if (!en && step == STEP_UP) begin
        q_d    = inc_val;
        dir_d  = 1'b1;
        wrap_d = all9;
      end else if (!en && step == STEP_DN) begin
        q_d    = dec_val;
        dir_d  = 1'b0;
        wrap_d = all0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sa_q    <= '0;
      sb_q    <= '0;
      prev_q  <= 2'b00;
      prime_q <= PRIME_INIT;
      q_q     <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sa_q    <= {sa_q[SYNC_STAGES-2:0], qa};
      sb_q    <= {sb_q[SYNC_STAGES-2:0], qb};
      prev_q  <= prev_d;
      prime_q <= prime_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign q      = q_q;
  assign dir    = dir_q;
  assign wrap   = wrap_q;
  assign err    = err_q;
  assign maxmin = dir_q ? all9 : all0;

endmodule
